// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit.
// The FSM state encodings are kept as plain constants for compatibility with older code.
package fetch_unit_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'h0000_0004;

   typedef logic [1:0] state_t;

   localparam state_t ST_BOOT  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master) and
// the instruction memory (slave).
interface fetch_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  imem_req;
   logic [DATA_WIDTH-1:0] imem_addr;
   logic                  imem_gnt;
   logic                  imem_rvalid;
   logic [DATA_WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instruction} pairs; the head is
// visible combinationally and flush empties it in one cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_pop_s;
   logic             do_push_s;

   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];

   // Storage array, data only.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/fetch_unit_chk.sv
// Run-time checks on the fetch unit's response bookkeeping.
module fetch_unit_chk (
   input logic clk,
   input logic rstn,
   input logic push,
   input logic pop,
   input logic full,
   input logic rsp_untracked
);

   // Buffer overflow and responses that match no issued request.
   always_ff @(posedge clk) begin
      if (rstn) begin
         a_no_push_full: assert (!(push && full && !pop))
            else $error("fetch_unit: response arrived with fetch buffer full");
         a_rsp_tracked: assert (!rsp_untracked)
            else $error("fetch_unit: response with nothing in flight");
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-based request issue, in-order response
// buffering and flush/drain handling ahead of the IF/ID register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = XLEN,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   fetch_unit_if.master          imem,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic                  if_en,
   output logic                  if_clr
);
   localparam int                    CW   = $clog2(FIFO_DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

   state_t                  state_r, state_nxt_s;
   logic [DATA_WIDTH-1:0]   pc_r, pc_nxt_s;
   logic [DATA_WIDTH-1:0]   rsp_pc_r, rsp_pc_nxt_s;
   logic [DATA_WIDTH-1:0]   target_s;
   logic [CW-1:0]           outstanding_r, outstanding_nxt_s;
   logic [CW-1:0]           drop_r, drop_nxt_s;
   logic [CW-1:0]           fifo_count_s;
   logic [CW:0]             credit_s;
   logic [CW:0]             flush_drop_s;
   logic                    fire_s, take_s, discard_s, push_s, pop_s;
   logic                    fifo_full_s, fifo_empty_s;
   logic [2*DATA_WIDTH-1:0] head_s;
   logic                    unused_s;

   assign target_s = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
   assign unused_s = ^redirect_pc[1:0];

   assign if_valid = !fifo_empty_s;
   assign if_pc    = if_valid ? head_s[2*DATA_WIDTH-1:DATA_WIDTH] : {DATA_WIDTH{1'b0}};
   assign if_instr = if_valid ? head_s[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP_INSTR);
   assign if_en    = !stall;
   assign if_clr   = flush | !if_valid;
   assign pop_s    = if_valid & !stall;

   // A same-cycle pop frees its slot, so a 1-cycle memory can sustain one fetch per cycle.
   assign credit_s       = {1'b0, outstanding_r} + {1'b0, fifo_count_s} - {{CW{1'b0}}, pop_s};
   assign imem.imem_req  = (state_r == ST_RUN) && !flush && (credit_s < (CW+1)'(FIFO_DEPTH));
   assign imem.imem_addr = pc_r;

   assign fire_s    = imem.imem_req & imem.imem_gnt;
   assign take_s    = imem.imem_rvalid && (drop_r == {CW{1'b0}});
   assign discard_s = imem.imem_rvalid && (drop_r != {CW{1'b0}});
   assign push_s    = take_s && !flush;

   // Everything still in flight after a flush cycle must be discarded.
   assign flush_drop_s = {1'b0, drop_r} + {1'b0, outstanding_r}
                       + {{CW{1'b0}}, fire_s} - {{CW{1'b0}}, imem.imem_rvalid};

   // Next-state logic for the FSM, PCs and in-flight counters.
   always_comb begin
      state_nxt_s       = state_r;
      pc_nxt_s          = pc_r;
      rsp_pc_nxt_s      = rsp_pc_r;
      outstanding_nxt_s = outstanding_r;
      drop_nxt_s        = drop_r;
      if (flush) begin
         pc_nxt_s          = target_s;
         rsp_pc_nxt_s      = target_s;
         outstanding_nxt_s = {CW{1'b0}};
         drop_nxt_s        = flush_drop_s[CW-1:0];
         if (flush_drop_s != {(CW+1){1'b0}}) begin
            state_nxt_s = ST_DRAIN;
         end else begin
            state_nxt_s = ST_RUN;
         end
      end else begin
         if (fire_s) begin
            pc_nxt_s = pc_r + STEP;
         end else begin
            pc_nxt_s = pc_r;
         end
         if (take_s) begin
            rsp_pc_nxt_s = rsp_pc_r + STEP;
         end else begin
            rsp_pc_nxt_s = rsp_pc_r;
         end
         outstanding_nxt_s = outstanding_r + CW'(fire_s) - CW'(take_s);
         drop_nxt_s        = drop_r - CW'(discard_s);
         case (state_r)
            ST_BOOT:  state_nxt_s = ST_RUN;
            ST_RUN:   state_nxt_s = ST_RUN;
            ST_DRAIN: begin
               if (discard_s && (drop_r == CW'(1))) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end
            default:  state_nxt_s = ST_BOOT;
         endcase
      end
   end

   // FSM, PC and counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= ST_BOOT;
         pc_r          <= RESET_PC;
         rsp_pc_r      <= RESET_PC;
         outstanding_r <= {CW{1'b0}};
         drop_r        <= {CW{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         rsp_pc_r      <= rsp_pc_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         drop_r        <= drop_nxt_s;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*DATA_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush),
      .din   ({rsp_pc_r, imem.imem_rdata}),
      .dout  (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   fetch_unit_chk u_chk (
      .clk           (clk),
      .rstn          (rstn),
      .push          (push_s),
      .pop           (pop_s),
      .full          (fifo_full_s),
      .rsp_untracked (imem.imem_rvalid && (outstanding_r == {CW{1'b0}}) && (drop_r == {CW{1'b0}}))
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based instruction memory with
// programmable latency, and hand-computed expectations at each step.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_en;
   logic        if_clr;

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   int cycnum   = 0;
   logic [31:0] q_addr [$];
   int          q_due  [$];

   fetch_unit_if #(.DATA_WIDTH(32)) mif ();

   fetch_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .imem        (mif),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_en       (if_en),
      .if_clr      (if_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of the memory model: record grants, retire the presented response,
   // present the next one once its latency has elapsed.
   task automatic cyc();
      logic        fire;
      logic        took;
      logic [31:0] a;
      fire = mif.imem_req & mif.imem_gnt;
      took = mif.imem_rvalid;
      a    = mif.imem_addr;
      @(posedge clk);
      #1;
      if (took) begin
         q_addr.delete(0);
         q_due.delete(0);
      end
      if (fire) begin
         q_addr.push_back(a);
         q_due.push_back(cycnum + lat);
      end
      cycnum++;
      if (q_due.size() > 0 && q_due[0] <= cycnum) begin
         mif.imem_rvalid = 1'b1;
         mif.imem_rdata  = instr_of(q_addr[0]);
      end else begin
         mif.imem_rvalid = 1'b0;
         mif.imem_rdata  = 32'h0000_0000;
      end
   endtask

   task automatic mem_reset();
      q_addr.delete();
      q_due.delete();
      mif.imem_rvalid = 1'b0;
      mif.imem_rdata  = 32'h0000_0000;
   endtask

   initial begin
      rstn        = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      redirect_pc = 32'h0000_0000;
      mif.imem_gnt = 1'b1;
      mem_reset();
      cyc(); cyc(); #1;
      chk1 ("rst_req",    mif.imem_req, 1'b0);
      chk1 ("rst_valid",  if_valid,     1'b0);
      chk32("rst_instr",  if_instr,     32'h0000_0013);
      chk1 ("rst_clr",    if_clr,       1'b1);
      chk1 ("rst_en",     if_en,        1'b1);
      stall = 1'b1; #1;
      chk1 ("rst_en_stall", if_en, 1'b0);
      stall = 1'b0;

      // Latency 1, always granted: back-to-back fetch from 0x0.
      rstn = 1'b1; #1;
      chk1 ("boot_req", mif.imem_req, 1'b0);
      cyc(); #1;
      chk1 ("c2_req",  mif.imem_req,  1'b1);
      chk32("c2_addr", mif.imem_addr, 32'h0000_0000);
      cyc(); #1;
      chk1 ("c3_valid", if_valid,      1'b0);
      chk32("c3_addr",  mif.imem_addr, 32'h0000_0004);
      cyc(); #1;
      chk1 ("c4_valid", if_valid,      1'b1);
      chk32("c4_pc",    if_pc,         32'h0000_0000);
      chk32("c4_instr", if_instr,      32'hC0DE_0000);
      chk1 ("c4_clr",   if_clr,        1'b0);
      chk32("c4_addr",  mif.imem_addr, 32'h0000_0008);
      cyc(); #1;
      chk32("c5_pc", if_pc, 32'h0000_0004);
      cyc(); #1;
      chk32("c6_pc", if_pc, 32'h0000_0008);

      // Three stall cycles: head frozen, credits exhausted, then resume.
      cyc(); stall = 1'b1; #1;
      chk32("st1_pc",  if_pc,        32'h0000_000C);
      chk1 ("st1_req", mif.imem_req, 1'b0);
      chk1 ("st1_en",  if_en,        1'b0);
      cyc(); #1;
      chk32("st2_pc",  if_pc,        32'h0000_000C);
      chk1 ("st2_req", mif.imem_req, 1'b0);
      cyc(); #1;
      chk32("st3_pc",  if_pc,        32'h0000_000C);
      chk1 ("st3_req", mif.imem_req, 1'b0);
      cyc(); stall = 1'b0; #1;
      chk32("rs0_pc",   if_pc,         32'h0000_000C);
      chk1 ("rs0_req",  mif.imem_req,  1'b1);
      chk32("rs0_addr", mif.imem_addr, 32'h0000_0014);
      cyc(); #1;
      chk32("rs1_pc", if_pc, 32'h0000_0010);
      cyc(); #1;
      chk32("rs2_pc", if_pc, 32'h0000_0014);

      // Flush coinciding with the only outstanding response; unaligned target.
      cyc(); flush = 1'b1; redirect_pc = 32'h0000_0202; #1;
      chk1 ("fl_rvalid_seen", mif.imem_rvalid, 1'b1);
      chk1 ("fl_req", mif.imem_req, 1'b0);
      chk1 ("fl_clr", if_clr,       1'b1);
      cyc(); flush = 1'b0; #1;
      chk1 ("fl1_req",   mif.imem_req,  1'b1);
      chk32("fl1_addr",  mif.imem_addr, 32'h0000_0200);
      chk1 ("fl1_valid", if_valid,      1'b0);
      cyc(); #1;
      chk1 ("fl2_valid", if_valid, 1'b0);
      chk32("fl2_instr", if_instr, 32'h0000_0013);
      cyc(); #1;
      chk1 ("fl3_valid", if_valid, 1'b1);
      chk32("fl3_pc",    if_pc,    32'h0000_0200);

      // Redirect to the top word: fetch address wraps to zero.
      flush = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
      chk1 ("wr_clr", if_clr, 1'b1);
      cyc(); flush = 1'b0; #1;
      chk32("wr1_addr", mif.imem_addr, 32'hFFFF_FFFC);
      cyc(); #1;
      chk32("wr2_addr", mif.imem_addr, 32'h0000_0000);
      chk1 ("wr2_req",  mif.imem_req,  1'b1);
      cyc(); #1;
      chk32("wr3_pc", if_pc, 32'hFFFF_FFFC);
      cyc(); #1;
      chk32("wr4_pc", if_pc, 32'h0000_0000);

      // Reset mid-transaction; outputs go to reset values immediately.
      stall = 1'b1;
      rstn  = 1'b0;
      mem_reset();
      #1;
      chk1 ("mr_req",   mif.imem_req, 1'b0);
      chk1 ("mr_valid", if_valid,     1'b0);
      chk32("mr_instr", if_instr,     32'h0000_0013);
      chk1 ("mr_clr",   if_clr,       1'b1);
      chk1 ("mr_en",    if_en,        1'b0);
      cyc(); cyc();
      stall = 1'b0;
      lat   = 3;
      rstn  = 1'b1; #1;
      chk1 ("mr_boot_req", mif.imem_req, 1'b0);
      cyc(); #1;
      chk32("mr_restart_addr", mif.imem_addr, 32'h0000_0000);
      chk1 ("mr_restart_req",  mif.imem_req,  1'b1);
      cyc(); #1;
      chk32("dr0_addr", mif.imem_addr, 32'h0000_0004);

      // Two requests in flight at latency 3, then redirect to 0x103.
      cyc(); #1;
      chk1 ("dr1_req", mif.imem_req, 1'b0);
      flush = 1'b1; redirect_pc = 32'h0000_0103; #1;
      chk1 ("dr1_clr", if_clr, 1'b1);
      cyc(); flush = 1'b0; #1;
      chk1 ("dr2_req",   mif.imem_req, 1'b0);
      chk1 ("dr2_valid", if_valid,     1'b0);
      cyc(); #1;
      chk1 ("dr3_req",   mif.imem_req, 1'b0);
      chk1 ("dr3_valid", if_valid,     1'b0);
      cyc(); #1;
      chk1 ("dr4_req",   mif.imem_req,  1'b1);
      chk32("dr4_addr",  mif.imem_addr, 32'h0000_0100);
      cyc(); #1;
      chk32("dr5_addr",  mif.imem_addr, 32'h0000_0104);
      chk1 ("dr5_valid", if_valid,      1'b0);
      cyc(); #1;
      chk1 ("dr6_req",   mif.imem_req, 1'b0);
      cyc(); #1;
      chk1 ("dr7_valid", if_valid, 1'b0);
      cyc(); #1;
      chk1 ("dr8_valid", if_valid, 1'b1);
      chk32("dr8_pc",    if_pc,    32'h0000_0100);
      chk32("dr8_instr", if_instr, 32'hC0DE_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
